// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline (ID stage).
// Optional load-use stall counter enabled by defining HFU_STATS_EN.
module hazard_forward_unit #(
  parameter int RA_W = 5
`ifdef HFU_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic            id_branch_taken,
  input  logic            ext_stall,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble
`ifdef HFU_STATS_EN
  , output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [1:0]      SEL_RF    = 2'b00;
  localparam logic [1:0]      SEL_EXMEM = 2'b01;
  localparam logic [1:0]      SEL_MEMWB = 2'b10;
  localparam logic [RA_W-1:0] REG_ZERO  = {RA_W{1'b0}};

  state_t     state_r, state_nxt_s;
  logic       load_use_s;
  logic       bubble_s;
  logic       enter_stall_s;
  logic [1:0] next_a_s, next_b_s;

  // EX producer is the youngest value, so it outranks MEM; $0 is hardwired.
  function automatic logic [1:0] sel_for(
    input logic [RA_W-1:0] src,
    input logic [RA_W-1:0] e_rd,
    input logic            e_wr,
    input logic            e_ld,
    input logic [RA_W-1:0] m_rd,
    input logic            m_wr
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src == REG_ZERO) begin
      sel = SEL_RF;
    end else if (e_wr && !e_ld && (e_rd == src)) begin
      sel = SEL_EXMEM;
    end else if (m_wr && (m_rd == src)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  assign next_a_s      = sel_for(id_rs, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write);
  assign next_b_s      = sel_for(id_rt, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write);
  assign load_use_s    = ex_mem_read && (ex_rd != REG_ZERO) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign bubble_s      = (state_r == RUN) && load_use_s;
  assign enter_stall_s = bubble_s && !ext_stall;

  // Next-state logic: a load-use stall lasts one unfrozen cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (enter_stall_s) begin
          state_nxt_s = STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STALL: begin
        if (ext_stall) begin
          state_nxt_s = STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Forwarding selects for the EX stage; frozen under ext_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else if (ext_stall) begin
      fwd_a_sel <= fwd_a_sel;
      fwd_b_sel <= fwd_b_sel;
    end else if (bubble_s) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      fwd_a_sel <= next_a_s;
      fwd_b_sel <= next_b_s;
    end
  end

  // Pipeline register controls; a pending stall suppresses a taken-branch flush.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end else if (ext_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end else if (bubble_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = id_branch_taken;
      idex_bubble = 1'b0;
    end
  end

`ifdef HFU_STATS_EN
  // Saturating count of stall entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (enter_stall_s && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count <= stall_count;
    end
  end
`else
  logic unused_enter_s;
  assign unused_enter_s = enter_stall_s;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus
// randomized traffic against a behavioural model of the forwarding rules.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, id_branch_taken, ext_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
`ifdef HFU_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_stall;
  logic [1:0] m_a, m_b;
  int         m_cnt;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .id_branch_taken(id_branch_taken),
    .ext_stall(ext_stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble)
`ifdef HFU_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (ex_reg_write && !ex_mem_read && ex_rd == src) return 2'b01;
    if (mem_reg_write && mem_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_load_use();
    return ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
  endfunction

  task automatic model_reset();
    m_stall = 1'b0;
    m_a = 2'b00;
    m_b = 2'b00;
    m_cnt = 0;
  endtask

  task automatic drive(input logic [4:0] rs, rt, erd, input logic ew, emr,
                       input logic [4:0] mrd, input logic mw, br, es);
    @(negedge clk);
    id_rs = rs; id_rt = rt; ex_rd = erd; ex_reg_write = ew; ex_mem_read = emr;
    mem_rd = mrd; mem_reg_write = mw; id_branch_taken = br; ext_stall = es;
  endtask

  // Checks controls mid-cycle, advances the model, checks selects after the edge.
  task automatic cycle();
    bit stall_now;
    logic [3:0] exp_ctl;
    #1;
    stall_now = !m_stall && exp_load_use();
    if (ext_stall)      exp_ctl = 4'b0000;
    else if (stall_now) exp_ctl = 4'b0001;
    else                exp_ctl = {2'b11, id_branch_taken, 1'b0};
    check("ctl{pc,ifid,flush,bubble}", {pc_write, ifid_write, ifid_flush, idex_bubble}, exp_ctl);
    if (!ext_stall) begin
      if (stall_now) begin
        m_stall = 1'b1; m_a = 2'b00; m_b = 2'b00;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_stall = 1'b0; m_a = exp_sel(id_rs); m_b = exp_sel(id_rt);
      end
    end
    @(posedge clk);
    #1;
    check("fwd_a_sel", fwd_a_sel, m_a);
    check("fwd_b_sel", fwd_b_sel, m_b);
`ifdef HFU_STATS_EN
    check("stall_count", stall_count, m_cnt);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs = 5'd7; id_rt = 5'd0; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    mem_rd = 5'd0; mem_reg_write = 1'b0; id_branch_taken = 1'b1; ext_stall = 1'b0;
    model_reset();
    #2;
    check("reset ctl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);
    check("reset sels", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU dependency
    drive(5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0); cycle();
    check("s1 fwd_a", fwd_a_sel, 2'b01);
    // 2: two-back, then both stages match
    drive(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); cycle();
    check("s2 fwd_b mem", fwd_b_sel, 2'b10);
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); cycle();
    check("s2 fwd_b ex prio", fwd_b_sel, 2'b01);
    // 3: load-use
    drive(5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    check("s3 stall ctl", {pc_write, ifid_write, idex_bubble}, 3'b001); cycle();
    check("s3 bubble sels", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    drive(5'd7, 5'd2, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); #1;
    check("s3 resume pc", pc_write, 1'b1); cycle();
    check("s3 fwd_a mem", fwd_a_sel, 2'b10);
`ifdef HFU_STATS_EN
    check("s3 stall_count", stall_count, 16'd1);
`endif
    // 4: $0 filter
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); cycle();
    check("s4 sel zero", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cycle();
    // 5: branch vs stall
    drive(5'd8, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); #1;
    check("s5 flush suppressed", ifid_flush, 1'b0); cycle();
    drive(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); #1;
    check("s5 flush", ifid_flush, 1'b1); cycle();
    // 6: ext_stall during STALL, then reset mid-stall
    drive(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1); cycle();
    end
    check("s6 frozen pc", pc_write, 1'b0);
    drive(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("s6 reset ctl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);
    check("s6 reset sels", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic with small register numbers to force collisions
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
